// File: rtl/morph_pkg.sv
// Shared types and constants for the 7x7 binary morphology block.
package morph_pkg;

  typedef enum logic [1:0] {
    MORPH_ERODE  = 2'd0,
    MORPH_DILATE = 2'd1,
    MORPH_THRESH = 2'd2,
    MORPH_PASS   = 2'd3
  } morph_mode_e;

  localparam int WIN        = 7;
  localparam int WIN_BITS   = 49;
  localparam int CENTER_IDX = 24;
  localparam int SUM_W      = 6;
  localparam int POP_W      = 3;

  // Per-window decision from the ones count (or the centre bit in pass mode).
  function automatic logic morph_decide(input morph_mode_e mode,
                                        input logic [SUM_W-1:0] sum,
                                        input logic [SUM_W-1:0] thresh,
                                        input logic center);
    logic res;
    res = 1'b0;
    case (mode)
      MORPH_ERODE:  res = (sum == SUM_W'(WIN_BITS));
      MORPH_DILATE: res = (sum != '0);
      MORPH_THRESH: res = (sum >= thresh);
      default:      res = center;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morph_popcnt7.sv
// Combinational population count of one 7-pixel window row.
module morph_popcnt7
  import morph_pkg::*;
(
  input  logic [WIN-1:0]   bits_i,
  output logic [POP_W-1:0] count_o
);

  // Add up the set bits of the row
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIN; i++) begin
      count_o = count_o + POP_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bin_morph_7x7.sv
// 7x7 binary morphology (erode / dilate / threshold / pass) over a window
// stream, 3-cycle pipeline with matching sync delay and border masking.
// Optional per-frame ones counter on port frame_ones when MORPH_STATS_EN is defined.
module bin_morph_7x7
  import morph_pkg::*;
#(
  parameter int         IMG_HDISP  = 640,
  parameter int         IMG_VDISP  = 480,
  parameter logic [5:0] DEF_THRESH = 6'd25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                matrix_frame_vsync,
  input  logic                matrix_frame_href,
  input  logic                matrix_frame_clken,
  input  logic [WIN_BITS-1:0] matrix_in,
  input  logic [1:0]          mode_i,
  input  logic [5:0]          thresh_i,
  output logic                post_frame_vsync,
  output logic                post_frame_href,
  output logic                post_frame_clken,
  output logic                post_img_Bit
`ifdef MORPH_STATS_EN
  ,
  output logic [18:0]         frame_ones
`endif
);

  localparam int COL_W = $clog2(IMG_HDISP + 1);
  localparam int ROW_W = $clog2(IMG_VDISP);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

  // Control delay lines: bit 0 is one cycle late, bit 2 drives the outputs.
  logic [2:0] vsync_pipe_q, vsync_pipe_d;
  logic [2:0] href_pipe_q, href_pipe_d;
  logic [2:0] clken_pipe_q, clken_pipe_d;

  morph_mode_e      mode_q, mode_d;
  logic [SUM_W-1:0] thresh_q, thresh_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;

  logic [WIN-1:0][POP_W-1:0] pop_w, pop_q, pop_d;
  logic                      center1_q, center1_d, ok1_q, ok1_d;
  logic [SUM_W-1:0]          sum_w, sum_q, sum_d;
  logic                      center2_q, center2_d, ok2_q, ok2_d;
  logic                      bit_q, bit_d;

  logic vsync_rise, href_fall, border_ok_w;

  assign vsync_rise  = matrix_frame_vsync & ~vsync_pipe_q[0];
  assign href_fall   = href_pipe_q[0] & ~matrix_frame_href;
  // A window is complete only once 7 columns and 7 lines have been seen.
  assign border_ok_w = (col_cnt_q >= COL_W'(WIN - 1)) && (row_cnt_q >= ROW_W'(WIN - 1));

  generate
    for (genvar gi = 0; gi < WIN; gi++) begin : g_row_pop
      morph_popcnt7 u_popcnt (
        .bits_i  (matrix_in[gi*WIN +: WIN]),
        .count_o (pop_w[gi])
      );
    end
  endgenerate

  // Sync delay lines, frame-stable configuration and position counters
  always_comb begin
    vsync_pipe_d = {vsync_pipe_q[1:0], matrix_frame_vsync};
    href_pipe_d  = {href_pipe_q[1:0], matrix_frame_href};
    clken_pipe_d = {clken_pipe_q[1:0], matrix_frame_clken};

    mode_d   = mode_q;
    thresh_d = thresh_q;
    if (vsync_rise) begin
      mode_d   = morph_mode_e'(mode_i);
      thresh_d = thresh_i;
    end

    col_cnt_d = col_cnt_q;
    if (!matrix_frame_href) begin
      col_cnt_d = '0;
    end else if (matrix_frame_clken) begin
      col_cnt_d = col_cnt_q + COL_W'(1);
    end

    row_cnt_d = row_cnt_q;
    if (vsync_rise) begin
      row_cnt_d = '0;
    end else if (href_fall && (row_cnt_q != ROW_MAX)) begin
      row_cnt_d = row_cnt_q + ROW_W'(1);
    end
  end

  // Data stages: row popcounts, window sum, masked decision
  always_comb begin
    sum_w = '0;
    for (int i = 0; i < WIN; i++) begin
      sum_w = sum_w + SUM_W'(pop_q[i]);
    end

    pop_d     = matrix_frame_clken ? pop_w : pop_q;
    center1_d = matrix_frame_clken ? matrix_in[CENTER_IDX] : center1_q;
    ok1_d     = matrix_frame_clken ? border_ok_w : ok1_q;

    sum_d     = clken_pipe_q[0] ? sum_w : sum_q;
    center2_d = clken_pipe_q[0] ? center1_q : center2_q;
    ok2_d     = clken_pipe_q[0] ? ok1_q : ok2_q;

    bit_d = bit_q;
    if (!href_pipe_q[1]) begin
      bit_d = 1'b0;
    end else if (clken_pipe_q[1]) begin
      bit_d = ok2_q & morph_decide(mode_q, sum_q, thresh_q, center2_q);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_pipe_q <= '0;
      href_pipe_q  <= '0;
      clken_pipe_q <= '0;
      mode_q       <= MORPH_ERODE;
      thresh_q     <= DEF_THRESH;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pop_q        <= '0;
      center1_q    <= 1'b0;
      ok1_q        <= 1'b0;
      sum_q        <= '0;
      center2_q    <= 1'b0;
      ok2_q        <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      vsync_pipe_q <= vsync_pipe_d;
      href_pipe_q  <= href_pipe_d;
      clken_pipe_q <= clken_pipe_d;
      mode_q       <= mode_d;
      thresh_q     <= thresh_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pop_q        <= pop_d;
      center1_q    <= center1_d;
      ok1_q        <= ok1_d;
      sum_q        <= sum_d;
      center2_q    <= center2_d;
      ok2_q        <= ok2_d;
      bit_q        <= bit_d;
    end
  end

  assign post_frame_vsync = vsync_pipe_q[2];
  assign post_frame_href  = href_pipe_q[2];
  assign post_frame_clken = clken_pipe_q[2];
  assign post_img_Bit     = bit_q;

`ifdef MORPH_STATS_EN
  logic [18:0] acc_q, acc_d, acc_inc_w, frame_ones_q, frame_ones_d;
  logic        post_vs_prev_q;

  // Count valid output ones per frame; publish and restart on output vsync rise
  always_comb begin
    acc_inc_w = acc_q;
    if (post_frame_clken && post_frame_href && post_img_Bit && (acc_q != '1)) begin
      acc_inc_w = acc_q + 19'd1;
    end
    acc_d        = acc_inc_w;
    frame_ones_d = frame_ones_q;
    if (post_frame_vsync && !post_vs_prev_q) begin
      frame_ones_d = acc_inc_w;
      acc_d        = '0;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      frame_ones_q   <= '0;
      post_vs_prev_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      frame_ones_q   <= frame_ones_d;
      post_vs_prev_q <= post_frame_vsync;
    end
  end

  assign frame_ones = frame_ones_q;
`endif

endmodule

// File: tb/tb_bin_morph_7x7.sv
// Self-checking bench for bin_morph_7x7: image frames are streamed as 7x7
// windows, expected pixels go to a scoreboard queue, and the output side
// checks the 3-cycle sync delay, pixel values, hold and href-low zeroing.
module tb_bin_morph_7x7;

  localparam int H = 20;
  localparam int W = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, hr, ck;
  logic [48:0] win;
  logic [1:0]  mode_i;
  logic [5:0]  thresh_i;
  logic        pvs, phr, pck, pbit;
`ifdef MORPH_STATS_EN
  logic [18:0] frame_ones;
`endif

  always #5 clk = ~clk;

  bin_morph_7x7 #(.IMG_HDISP(W), .IMG_VDISP(H)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matrix_frame_vsync (vs),
    .matrix_frame_href  (hr),
    .matrix_frame_clken (ck),
    .matrix_in          (win),
    .mode_i             (mode_i),
    .thresh_i           (thresh_i),
    .post_frame_vsync   (pvs),
    .post_frame_href    (phr),
    .post_frame_clken   (pck),
    .post_img_Bit       (pbit)
`ifdef MORPH_STATS_EN
    ,
    .frame_ones         (frame_ones)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  bit   img [0:H-1][0:W-1];
  bit   exp_q [$];
  logic [2:0] hist [0:2];
  logic last_exp;
  int   cur_mode = 0;
  int   cur_th   = 25;
  logic prev_vs  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] win_at(input int r, input int c);
    logic [48:0] w;
    int ir, ic;
    w = '0;
    for (int rr = 0; rr < 7; rr++) begin
      for (int cc = 0; cc < 7; cc++) begin
        ir = r - 6 + rr;
        ic = c - cc;
        if (ir >= 0 && ic >= 0) w[rr*7+cc] = img[ir][ic];
      end
    end
    return w;
  endfunction

  function automatic logic exp_bit(input logic [48:0] w, input int r, input int c);
    int s;
    s = $countones(w);
    if (r < 6 || c < 6) return 1'b0;
    case (cur_mode)
      0:       return (s == 49);
      1:       return (s != 0);
      2:       return (s >= cur_th);
      default: return w[24];
    endcase
  endfunction

  // Output-side checker: sync delay, scoreboard pop, hold and zero rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {28'd0, pvs, phr, pck, pbit}, 32'd0);
      for (int i = 0; i < 3; i++) hist[i] = 3'b000;
      exp_q.delete();
      last_exp = 1'b0;
    end else begin
      chk("ctrl_delay3", {29'd0, pvs, phr, pck}, {29'd0, hist[2]});
      if (phr && pck) begin
        n_checks++;
        assert (exp_q.size() != 0) n_pass++;
        else begin
          n_fail++;
          $error("FAIL pixel_extra observed=%0d expected=none", pbit);
        end
        if (exp_q.size() != 0) begin
          last_exp = exp_q.pop_front();
          chk("pixel", {31'd0, pbit}, {31'd0, last_exp});
        end
      end else if (phr) begin
        chk("hold", {31'd0, pbit}, {31'd0, last_exp});
      end else begin
        chk("href_low_zero", {31'd0, pbit}, 32'd0);
        last_exp = 1'b0;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {vs, hr, ck};
    end
  end

  task automatic drive(input logic v, input logic h, input logic c, input int r, input int col);
    logic [48:0] w;
    @(posedge clk);
    #1;
    if (v && !prev_vs) begin
      cur_mode = int'(mode_i);
      cur_th   = int'(thresh_i);
    end
    prev_vs = v;
    w = (h && c) ? win_at(r, col) : {17'($urandom), $urandom};
    vs  = v;
    hr  = h;
    ck  = c;
    win = w;
    if (h && c) exp_q.push_back(exp_bit(w, r, col));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    chk("pre_reset_href", {31'd0, phr}, 32'd1);
    chk("pre_reset_bit", {31'd0, pbit}, 32'd1);
    vs = 1'b0; hr = 1'b0; ck = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {28'd0, pvs, phr, pck, pbit}, 32'd0);
    cur_mode = 0;
    cur_th   = 25;
    prev_vs  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int gap, input int rst_row, input int chg_row,
                            input logic [1:0] chg_mode);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == chg_row && c == 0) mode_i = chg_mode;
        for (int g = 1; g < gap; g++) drive(0, 1, 0, r, c);
        drive(0, 1, 1, r, c);
        if (r == rst_row && c == 12) begin
          pulse_reset();
          return;
        end
      end
      repeat (3) drive(0, 0, 0, 0, 0);
    end
    repeat (4) drive(0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = (r == 10 && c == 10);
          default: img[r][c] = 1'($urandom_range(0, 1));
        endcase
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b0; hr = 1'b0; ck = 1'b0; win = '0;
    mode_i = 2'd0; thresh_i = 6'd0;
    for (int i = 0; i < 3; i++) hist[i] = 3'b000;
    last_exp = 1'b0;
    repeat (3) @(negedge clk);
`ifdef MORPH_STATS_EN
    chk("reset_frame_ones", {13'd0, frame_ones}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All ones, erode: interior 1, border 0
    fill(0); mode_i = 2'd0; send_frame(1, -1, -1, 2'd0);
    // Single pixel: dilate gives a 7x7 block, erode gives nothing
    fill(1); mode_i = 2'd1; send_frame(1, -1, -1, 2'd0);
    mode_i = 2'd0; send_frame(1, -1, -1, 2'd0);
    // Threshold around 24/25 ones, then the 0 and 50 extremes
    fill(2); mode_i = 2'd2; thresh_i = 6'd25; send_frame(1, -1, -1, 2'd0);
    thresh_i = 6'd0;  send_frame(1, -1, -1, 2'd0);
    thresh_i = 6'd50; send_frame(1, -1, -1, 2'd0);
    // Mode change mid-frame only takes effect at the next frame
    fill(1); mode_i = 2'd0; send_frame(1, -1, 8, 2'd1);
    send_frame(1, -1, -1, 2'd0);
    // Gapped strobes, pass-through of the centre pixel
    fill(2); mode_i = 2'd3; send_frame(3, -1, -1, 2'd0);
    // Reset in the middle of a line
    fill(0); mode_i = 2'd0; send_frame(1, 12, -1, 2'd0);
    repeat (5) drive(0, 0, 0, 0, 0);
    // Clean frame after reset, then a vsync to publish statistics
    send_frame(1, -1, -1, 2'd0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (8) drive(0, 0, 0, 0, 0);
`ifdef MORPH_STATS_EN
    chk("frame_ones", {13'd0, frame_ones}, 32'd196);
`endif
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
